// File: rtl/md_pad_pkg.sv
// rtl/md_pad_pkg.sv - shared constants for the 6-button pad responder
package md_pad_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_ID      = 3'd3;
    localparam logic [2:0] PH_EXT_END = 3'd4;

    localparam int TIMEOUT_DEFAULT = 80000;
    localparam int TW_DEFAULT      = 17;

    // A fall after the extended-end phase starts a new read cycle at phase 1.
    function automatic logic [2:0] ph_advance(input logic [2:0] ph);
        return (ph == PH_EXT_END) ? 3'd1 : ph + 3'd1;
    endfunction

endpackage

// File: rtl/md_pad_th_timer.sv
// rtl/md_pad_th_timer.sv - TH edge detection and inactivity timer
module md_pad_th_timer #(
    parameter int TIMEOUT = 80000,
    parameter int TW      = 17
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_th,
    output logic o_fall,
    output logic o_edge,
    output logic o_at_limit,
    output logic o_expire
);

    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

    logic          r_th_q;
    logic [TW-1:0] r_tmr;

    assign o_fall     = r_th_q & ~i_th;
    assign o_edge     = r_th_q ^ i_th;
    assign o_at_limit = (r_tmr == LIMIT);
    assign o_expire   = o_at_limit & ~o_edge;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_th_q <= 1'b1;
            r_tmr  <= '0;
        end else begin
            r_th_q <= i_th;
            if (o_edge)
                r_tmr <= '0;
            else if (!o_at_limit)
                r_tmr <= r_tmr + TW'(1);
        end
    end

endmodule

// File: rtl/md_pad6_responder.sv
// rtl/md_pad6_responder.sv - 6-button pad responder; PAD_SMS_MODE_EN adds SMS 2-button mode
module md_pad6_responder
    import md_pad_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TW      = TW_DEFAULT
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        TH_i,
    input  logic [11:0] BTN,
    input  logic        MODE3,
`ifdef PAD_SMS_MODE_EN
    input  logic        SMS_MODE,
`endif
    output logic [6:0]  PAD_o,
    output logic [6:0]  PAD_d
);

    logic       w_fall;
    logic       w_edge;
    logic       w_at_limit;
    logic       w_expire;
    logic       w_sms;
    logic       w_th_sel;
    logic [2:0] w_cnt_base;
    logic [2:0] w_cnt_next;
    logic [5:0] w_levels;
    logic [2:0] r_cnt;

`ifdef PAD_SMS_MODE_EN
    assign w_sms = SMS_MODE;
`else
    assign w_sms = 1'b0;
`endif

    md_pad_th_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_th_timer (
        .i_clk      (MCLK),
        .i_reset    (RESET),
        .i_th       (TH_i),
        .o_fall     (w_fall),
        .o_edge     (w_edge),
        .o_at_limit (w_at_limit),
        .o_expire   (w_expire)
    );

    // A stale sequence counts as idle even when an edge lands on the timeout cycle.
    assign w_cnt_base = (w_expire | (w_edge & w_at_limit)) ? PH_IDLE : r_cnt;

    always_comb begin
        w_cnt_next = w_cnt_base;
        if (w_sms)
            w_cnt_next = PH_IDLE;
        else if (w_fall)
            w_cnt_next = MODE3 ? 3'd1 : ph_advance(w_cnt_base);
    end

    assign w_th_sel = TH_i | w_sms;

    always_comb begin
        w_levels = 6'h3F;
        if (w_th_sel) begin
            if (w_cnt_next == PH_ID)
                w_levels = ~{BTN[BTN_C], BTN[BTN_B], BTN[BTN_MODE],
                             BTN[BTN_X], BTN[BTN_Y], BTN[BTN_Z]};
            else
                w_levels = ~{BTN[BTN_C], BTN[BTN_B], BTN[BTN_RIGHT],
                             BTN[BTN_LEFT], BTN[BTN_DOWN], BTN[BTN_UP]};
        end else begin
            w_levels[5:4] = ~{BTN[BTN_START], BTN[BTN_A]};
            case (w_cnt_next)
                PH_ID:      w_levels[3:0] = 4'h0;
                PH_EXT_END: w_levels[3:0] = 4'hF;
                default:    w_levels[3:0] = {2'b00, ~BTN[BTN_DOWN], ~BTN[BTN_UP]};
            endcase
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_cnt <= PH_IDLE;
            PAD_o <= 7'h7F;
        end else begin
            r_cnt <= w_cnt_next;
            PAD_o <= {1'b1, w_levels};
        end
    end

    assign PAD_d = 7'h3F;

endmodule

// File: tb/tb_md_pad6_responder.sv
// tb/tb_md_pad6_responder.sv - self-checking bench for md_pad6_responder
module tb_md_pad6_responder;

    localparam int TO = 40;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic        TH_i;
    logic [11:0] BTN;
    logic        MODE3;
    logic        SMS_MODE;
    logic [6:0]  PAD_o;
    logic [6:0]  PAD_d;

    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    md_pad6_responder #(.TIMEOUT(TO), .TW(6)) dut (
        .MCLK     (MCLK),
        .RESET    (RESET),
        .TH_i     (TH_i),
        .BTN      (BTN),
        .MODE3    (MODE3),
`ifdef PAD_SMS_MODE_EN
        .SMS_MODE (SMS_MODE),
`endif
        .PAD_o    (PAD_o),
        .PAD_d    (PAD_d)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Pin-source table: >=0 button index, -1 pin forced low, -2 pin forced high.
    function automatic logic [6:0] model_pad(input logic th, input int ph, input logic [11:0] b);
        int src [6];
        logic [6:0] p;
        if (th && ph != 3)      src = '{0, 1, 2, 3, 5, 6};
        else if (th)            src = '{10, 9, 8, 11, 5, 6};
        else if (ph == 3)       src = '{-1, -1, -1, -1, 4, 7};
        else if (ph == 4)       src = '{-2, -2, -2, -2, 4, 7};
        else                    src = '{0, 1, -1, -1, 4, 7};
        p[6] = 1'b1;
        for (int i = 0; i < 6; i++)
            p[i] = (src[i] < 0) ? (src[i] == -2) : ~b[src[i]];
        return p;
    endfunction

    // Number of falls seen in the current read, where a read restarts after TO quiet cycles.
    function automatic int model_phase(input logic th_prev, input logic th, input int idle,
                                       input int ph, input logic m3, input logic sms);
        int base;
        base = (idle >= TO - 1) ? 0 : ph;
        if (sms)                 return 0;
        if (th_prev && !th)      return m3 ? 1 : (base % 4) + 1;
        return base;
    endfunction

    logic       m_th   = 1'b1;
    int         m_idle = 0;
    int         m_ph   = 0;
    logic [6:0] m_exp  = 7'h7F;

    always @(posedge MCLK) begin
        if (RESET) begin
            m_th   <= 1'b1;
            m_idle <= 0;
            m_ph   <= 0;
            m_exp  <= 7'h7F;
        end else begin
            m_th   <= TH_i;
            m_idle <= (TH_i != m_th) ? 0 : m_idle + 1;
            m_ph   <= model_phase(m_th, TH_i, m_idle, m_ph, MODE3, SMS_MODE);
            m_exp  <= model_pad(TH_i | SMS_MODE,
                                model_phase(m_th, TH_i, m_idle, m_ph, MODE3, SMS_MODE), BTN);
        end
    end

    always @(negedge MCLK) begin
        if (chk_en) begin
            check("model_pad", PAD_o, m_exp);
            check("model_drv", PAD_d, 7'h3F);
        end
    end

    task automatic tick();
        @(posedge MCLK);
        #2;
    endtask

    task automatic th_set(input logic v);
        TH_i = v;
        tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; TH_i = 1'b1; BTN = '0; MODE3 = 1'b0; SMS_MODE = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        check("reset_pad", PAD_o, 7'h7F);
        check("reset_drv", PAD_d, 7'h3F);

        RESET = 1'b0; BTN = 12'h001;
        tick();
        check("up_pressed", PAD_o, 7'h7E);

        BTN = 12'h010;
        tick();
        check("a_hidden_th1", PAD_o, 7'h7F);
        th_set(1'b0); check("three_btn_low", PAD_o, 7'h63);
        th_set(1'b1); check("three_btn_high", PAD_o, 7'h7F);

        do_reset();
        BTN = 12'h100;
        th_set(1'b0); th_set(1'b1);
        th_set(1'b0); th_set(1'b1);
        th_set(1'b0); check("six_btn_id", PAD_o, 7'h70);
        th_set(1'b1); check("six_btn_xyz", PAD_o, 7'h7B);
        th_set(1'b0); check("six_btn_ext_end", PAD_o, 7'h7F);
        th_set(1'b1); check("six_btn_after", PAD_o, 7'h7F);

        do_reset();
        BTN = 12'h110;
        th_set(1'b0); th_set(1'b1); th_set(1'b0); th_set(1'b1);
        repeat (TO - 2) tick();
        th_set(1'b0); check("timeout_just_before", PAD_o, 7'h60);
        th_set(1'b1); check("timeout_before_xyz", PAD_o, 7'h7B);

        do_reset();
        th_set(1'b0); th_set(1'b1); th_set(1'b0); th_set(1'b1);
        repeat (TO - 1) tick();
        th_set(1'b0); check("timeout_expired", PAD_o, 7'h63);
        th_set(1'b1); check("timeout_no_ext", PAD_o, 7'h7F);

        do_reset();
        BTN = 12'h100;
        th_set(1'b0); th_set(1'b1); th_set(1'b0); th_set(1'b1);
        do_reset();
        th_set(1'b0); check("midreset_fall1", PAD_o, 7'h73);
        th_set(1'b1); th_set(1'b0); check("midreset_fall2", PAD_o, 7'h73);
        th_set(1'b1); th_set(1'b0); check("midreset_fall3", PAD_o, 7'h70);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            th_set(1'b0); th_set(1'b1);
        end
        th_set(1'b0); check("wrap_fall5", PAD_o, 7'h73);
        th_set(1'b1); check("wrap_high5", PAD_o, 7'h7F);
        th_set(1'b0); check("wrap_fall6", PAD_o, 7'h73);
        th_set(1'b1); check("wrap_no_ext", PAD_o, 7'h7F);

        do_reset();
        MODE3 = 1'b1; BTN = 12'h400;
        for (int i = 0; i < 5; i++) begin
            th_set(1'b0); check("mode3_low", PAD_o, 7'h73);
            th_set(1'b1); check("mode3_high", PAD_o, 7'h7F);
        end
        MODE3 = 1'b0;

`ifdef PAD_SMS_MODE_EN
        do_reset();
        SMS_MODE = 1'b1; BTN = 12'h020;
        for (int i = 0; i < 4; i++) begin
            th_set(1'b0); check("sms_low", PAD_o, 7'h6F);
            th_set(1'b1); check("sms_high", PAD_o, 7'h6F);
        end
        SMS_MODE = 1'b0;
`endif

        tick();
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_pad6_responder.md
Name: md_pad6_responder

Overview:
- Controller-side model of a 6-button Mega Drive/SMS-compatible pad, sitting on the peripheral end of one I/O controller port.
- Watches TH, which the I/O chip drives as output, and returns the multiplexed button state on pins 0..5.
- Tracks the TH falling-edge count and a timeout counter; both are needed to present the extended X/Y/Z/MODE nibble.
- Feeds the I/O controller's 7-bit port input (bit0 UP, bit1 DOWN, bit2 LEFT, bit3 RIGHT, bit4 TL, bit5 TR, bit6 TH).

Parameters:
- TIMEOUT, 80000, MCLK cycles without a TH edge after which the edge count returns to 0 (~1.5 ms at 53.7 MHz).
- TW, 17, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- MCLK  in  1  system clock; single clock domain.
- RESET  in  1  synchronous, active-high reset.
- TH_i  in  1  resolved TH pin level (port bit6 as seen on the wire).
- BTN  in  12  pressed=1: [0]UP [1]DOWN [2]LEFT [3]RIGHT [4]A [5]B [6]C [7]START [8]X [9]Y [10]Z [11]MODE.
- MODE3  in  1  1 = behave as 3-button pad (extended phases never entered).
- PAD_o  out  7  pin levels, active-low buttons; bit6 always 1.
- PAD_d  out  7  drive enables, 1 = pad drives the pin; constant 7'h3F.

Behaviour:
- Clock and reset: single clock MCLK; RESET is synchronous and active-high.
- Reset values: th_q=1, cnt=0, tmr=0, PAD_o=7'h7F, PAD_d=7'h3F.
- Every cycle th_q<=TH_i.
  - fall = th_q & ~TH_i.
  - edge = th_q ^ TH_i.
- Timer:
  - tmr<=0 on edge.
  - Otherwise tmr increments, saturating at TIMEOUT-1.
  - expire = (tmr==TIMEOUT-1) & ~edge.
- cnt (3-bit, values 0..4):
  - On expire, cnt<=0.
  - On fall, cnt<=(cnt==4 ? 1 : cnt+1).
  - If MODE3=1, fall sets cnt to 1 from any value.
  - An edge in the same cycle as tmr==TIMEOUT-1 first treats cnt as 0 (fall then gives cnt=1) and clears tmr.
- Output select uses the next-state values (TH_i, cnt_next). Pin values listed pin0..pin5 as pressed-state; each PAD_o bit = ~pressed, forced 1 where noted:
  - TH=1, cnt_next!=3: UP DOWN LEFT RIGHT B C.
  - TH=0, cnt_next in {0,1,2}: UP DOWN, pins2/3 driven 0, A START.
  - TH=0, cnt_next=3: pins0..3 driven 0, A START (6-button ID).
  - TH=1, cnt_next=3: Z Y X MODE B C.
  - TH=0, cnt_next=4: pins0..3 driven 1, A START.
- Latency: PAD_o is registered. It reflects a TH_i or BTN change exactly 1 MCLK later.
- Reset mid-sequence returns to cnt=0 immediately. The output register may differ from 7'h7F on the next cycle only via the normal select.

Optional Feature:
- Macro: PAD_SMS_MODE_EN.
- With the macro: adds input SMS_MODE (1 bit). When SMS_MODE=1:
  - TH is ignored and cnt is held at 0.
  - PAD_o = {1, ~C, ~B, ~RIGHT, ~LEFT, ~DOWN, ~UP}, i.e. SMS 2-button pad: button1=B on TL, button2=C on TR.
  - The timer still runs.
- Without the macro: no SMS_MODE port; behaviour as above.

Decomposition:
- Package md_pad_pkg:
  - button index constants (BTN_UP..BTN_MODE);
  - cnt phase constants (PH_IDLE=0, PH_ID=3, PH_EXT_END=4);
  - default TIMEOUT.
- Sub-module md_pad_th_timer: th_q register, edge/fall detection, tmr counter, expire.
  - Outputs fall, edge, expire.
  - The top keeps cnt and the output mux.

Test Plan:
- Reset: RESET=1 with TH_i=1, BTN=0 -> PAD_o=7'h7F, PAD_d=7'h3F; BTN[UP]=1 then TH steady -> PAD_o=7'h7E one cycle later.
- 3-button read: BTN[A]=1, toggle TH 1->0 -> PAD_o=7'h63 (pins2/3 low, A low, START high, bit6=1); TH back to 1 -> PAD_o=7'h7F.
- 6-button ID: BTN[X]=1, three TH falling edges within 100 cycles, then TH=0 -> pins0..3 = 0; then TH=1 -> PAD_o=7'h7B (X on pin2 low); then TH=0 -> pins0..3 = 1.
- Timeout: two falls, idle TIMEOUT cycles, then a third fall -> cnt=1, standard low-phase pattern, no ID nibble.
- Wrap: eight edges without pause, then two more falls -> cnt goes 4 -> 1 -> 2, no extended nibble on the following TH=1.
- MODE3=1: five fast TH cycles with BTN[Z]=1 -> PAD_o never shows Z and pins0..3 never all-zero while TH=0; with PAD_SMS_MODE_EN and SMS_MODE=1, BTN[B]=1 -> PAD_o=7'h6F regardless of TH.
